// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to add a parity bit before the stop bit.
module uart_tx #(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int PARITY_ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_tick,
  input  logic              start_trig,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_INV = 1'(PARITY_ODD != 0);
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign bit_end = b_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Ticks seen in the accept cycle are ignored (state is still IDLE).
    if (state_q != IDLE && b_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_trig) begin
          sh_d    = tx_data;
          tick_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ PAR_INV;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d = sh_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; the send side of the 16x-oversampled UART link that pairs with the team's receiver.
- Takes a parallel byte plus a one-cycle start strobe and serialises it on `tx`.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, 1 stop bit (1).
- Bit timing comes from the shared baud-tick generator (`b_tick`, 16 ticks per bit). Sits between the command/FIFO logic and the board TX pin.

Parameters:
- DATA_W, 8, number of data bits per frame.
- TICKS_PER_BIT, 16, `b_tick` pulses per serial bit. Must match the receiver oversample rate.
- PARITY_ODD, 0, parity sense when the optional feature is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- b_tick  in  1  baud oversample tick, one clk wide, TICKS_PER_BIT per bit period.
- start_trig  in  1  one-cycle request to send `tx_data`.
- tx_data  in  DATA_W  byte to send; sampled only when a start is accepted.
- tx  out  1  serial line; idle high; registered.
- tx_busy  out  1  high while a frame is in progress; registered.
- tx_done  out  1  one-clk pulse at end of the stop bit; registered.

Behaviour:
- Reset (rst=1 at a clk edge): tx=1, tx_busy=0, tx_done=0, state=IDLE, tick counter=0, bit counter=0, shift register=0. A reset mid-frame aborts the frame and drives tx=1 at that edge; no tx_done is produced.
- Counters: 4-bit tick counter (width clog2(TICKS_PER_BIT)) and a bit counter (clog2(DATA_W)). Both increment only on b_tick.
- Every state exit happens on the b_tick where the tick counter = TICKS_PER_BIT-1; the counter clears to 0 at that exit.
- IDLE:
  - tx=1, tx_busy=0.
  - tx_done is high only for the single cycle after STOP completes, then 0.
  - On start_trig=1: latch tx_data into the shift register, clear both counters, set tx_busy=1, go to START.
  - tx=0 appears at the same edge as the accept, so latency from start_trig to the falling start edge is 1 clk.
  - b_tick in the accept cycle is ignored.
- START: tx=0. After TICKS_PER_BIT b_ticks, go to DATA with tx = shift register bit 0.
- DATA:
  - tx = current LSB.
  - At each bit end, shift right by 1 and increment the bit counter.
  - When bit counter = DATA_W-1 at bit end, go to STOP (or PARITY if the feature is compiled in) with tx=1 (or the parity bit).
- STOP:
  - tx=1.
  - At bit end: tx_busy=0, tx_done=1 for exactly one clk, return to IDLE.
- start_trig while tx_busy=1 is ignored; no queuing, and tx_data changes mid-frame have no effect.
- start_trig in the same cycle tx_done=1 is accepted (state is already IDLE). This gives back-to-back frames with a 1-clk idle gap.
- b_tick held high continuously is legal: the frame then lasts TICKS_PER_BIT clk per bit.
- tx never glitches: it changes only at state/bit boundaries or on reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long.
  - tx = XOR of the latched data bits, inverted when PARITY_ODD=1.
  - Parity is computed from the byte latched at start, not the shifted register.
  - Frame = 11 bit periods for DATA_W=8.
- Undefined: no PARITY state, no parity logic; frame = 10 bit periods for DATA_W=8.

Test Plan:
- Reset: assert rst 3 clk mid-frame of 0xA5 -> tx=1, tx_busy=0, tx_done=0 on the first reset edge. After release, line stays idle with no tx_done.
- Single frame: b_tick every 10 clk, start_trig with tx_data=0x55 -> tx 1 clk later = 0, then bits 1,0,1,0,1,0,1,0, then 1. Each bit 160 clk ±10 clk tick phase. tx_done one pulse about 1600 clk after start; tx_busy falls on the same edge.
- Busy ignore: second start_trig with tx_data=0xFF at clk 500 of a 0x00 frame -> frame stays all-zero data, only one tx_done.
- Back-to-back: start_trig 0x0F issued in the tx_done cycle of a 0xF0 frame -> second start bit begins 1 clk after tx_done; received bytes 0xF0 then 0x0F. Check with the team uart_rx looped back: rx_data matches, rx_done count = 2.
- Continuous tick: b_tick=1 always, tx_data=0x81 -> bit periods exactly 16 clk; frame complete 160 clk after accept.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): tx_data=0x07 -> parity bit 1. With 0x55 -> parity bit 0. With PARITY_ODD=1 and 0x55 -> parity bit 1. tx_done at 11 bit periods.
